// File: rtl/ldst_pkg.sv
// Shared load/store channel types and sizing helpers for the ldst arbiter slice.
package ldst_pkg;

   localparam int LDST_AW = 32;
   localparam int LDST_DW = 32;

   typedef struct packed {
      logic [LDST_AW-1:0]   addr;
      logic                 st;
      logic [LDST_DW-1:0]   data;
      logic [LDST_DW/8-1:0] strobe;
   } ldst_req_t;

   typedef struct packed {
      logic [LDST_DW-1:0] data;
      logic               ok;
   } ldst_rsp_t;

   // Master index width; a single master still needs a 1-bit id.
   function automatic int calc_idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ldst_id_fifo.sv
// In-order FIFO of granted master ids; head is the owner of the next slave response.
module ldst_id_fifo #(
   parameter int DEPTH = 4,
   parameter int IDW   = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_push,
   input  logic [IDW-1:0] i_din,
   input  logic           i_pop,
   output logic [IDW-1:0] o_head,
   output logic           o_full,
   output logic           o_empty
);

   localparam int PW = $clog2(DEPTH);

   logic [IDW-1:0] r_mem [DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [PW:0]    r_count;
   logic           w_push;
   logic           w_pop;

   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/ldst_arb.sv
// N-master to 1-slave load/store arbiter: round-robin grant, zero-latency request
// pass-through, in-order response routing. LDST_ARB_FIXED_PRIO_EN selects fixed priority.
module ldst_arb
   import ldst_pkg::*;
#(
   parameter int NUM_MST    = 2,
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int OUTS_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_MST-1:0]              m_req_vld,
   output logic [NUM_MST-1:0]              m_req_rdy,
   input  logic [NUM_MST*(AW+1+DW+DW/8)-1:0] m_req_pkt,
   output logic [NUM_MST-1:0]              m_rsp_vld,
   input  logic [NUM_MST-1:0]              m_rsp_rdy,
   output logic [NUM_MST*(DW+1)-1:0]       m_rsp_pkt,
   output logic                            s_req_vld,
   input  logic                            s_req_rdy,
   output logic [AW+DW+DW/8:0]             s_req_pkt,
   input  logic                            s_rsp_vld,
   output logic                            s_rsp_rdy,
   input  logic [DW:0]                     s_rsp_pkt
);

   localparam int IDW  = calc_idw(NUM_MST);
   localparam int REQW = AW + 1 + DW + DW/8;

   logic [IDW-1:0]  r_rr_ptr;
   logic            r_lock;
   logic [IDW-1:0]  r_lock_id;
   logic [IDW-1:0]  w_gnt;
   logic [IDW-1:0]  w_hid;
   logic            w_any;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic [REQW-1:0] w_req_arr [NUM_MST];

   function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] g);
      return (int'(g) == NUM_MST-1) ? '0 : g + IDW'(1);
   endfunction

   for (genvar i = 0; i < NUM_MST; i++) begin : g_unpack
      assign w_req_arr[i] = m_req_pkt[i*REQW +: REQW];
   end

   assign w_any = |m_req_vld;

   if (NUM_MST == 1) begin : g_single
      assign w_gnt = '0;
   end else begin : g_multi
      logic [IDW-1:0] w_srch;
      always_comb begin
         int idx;
         idx    = 0;
         w_srch = r_rr_ptr;
`ifdef LDST_ARB_FIXED_PRIO_EN
         w_srch = '0;
         for (int k = NUM_MST-1; k >= 0; k--) begin
            if (m_req_vld[k]) w_srch = IDW'(k);
         end
`else
         // Scan from the far end back so the closest requester after rr_ptr wins.
         for (int k = NUM_MST-1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_MST) idx = idx - NUM_MST;
            if (m_req_vld[idx]) w_srch = IDW'(idx);
         end
`endif
      end
      // A stalled request keeps its grant so s_req_pkt cannot change mid-transfer.
      assign w_gnt = r_lock ? r_lock_id : w_srch;
   end

   assign s_req_vld = w_any & ~w_full;
   assign s_req_pkt = w_req_arr[w_gnt];
   assign w_push    = s_req_vld & s_req_rdy;

   always_comb begin
      m_req_rdy        = '0;
      m_req_rdy[w_gnt] = s_req_rdy & ~w_full;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr  <= '0;
         r_lock    <= 1'b0;
         r_lock_id <= '0;
      end else if (w_push) begin
`ifndef LDST_ARB_FIXED_PRIO_EN
         r_rr_ptr <= next_idx(w_gnt);
`endif
         r_lock   <= 1'b0;
      end else if (s_req_vld) begin
         r_lock    <= 1'b1;
         r_lock_id <= w_gnt;
      end
   end

   ldst_id_fifo #(
      .DEPTH (OUTS_DEPTH),
      .IDW   (IDW)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (w_gnt),
      .i_pop   (w_pop),
      .o_head  (w_hid),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Responses follow request order; the FIFO head names the owning master.
   assign s_rsp_rdy = m_rsp_rdy[w_hid] & ~w_empty;
   assign w_pop     = s_rsp_vld & s_rsp_rdy;
   assign m_rsp_pkt = {NUM_MST{s_rsp_pkt}};

   always_comb begin
      m_rsp_vld        = '0;
      m_rsp_vld[w_hid] = s_rsp_vld & ~w_empty;
   end

endmodule
